// File: rtl/bip_debug_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bip_debug_pkg
// Description : Shared types and constants for the BIP debug/host controller:
//               controller state enum, host command bytes, HLT opcode word.
// Revision    : 1.0 - initial release
// ============================================================================
package bip_debug_pkg;

    // Controller states; the RP_* group is walked by the report sequencer
    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        LD_HI   = 4'd1,
        LD_LO   = 4'd2,
        LD_WR   = 4'd3,
        LD_END  = 4'd4,
        RUN     = 4'd5,
        STEP    = 4'd6,
        RST     = 4'd7,
        RP_PCH  = 4'd8,
        RP_PCL  = 4'd9,
        RP_RD   = 4'd10,
        RP_WAIT = 4'd11,
        RP_DH   = 4'd12,
        RP_DL   = 4'd13
    } dbg_state_e;

    localparam logic [7:0]  c_CMD_LOAD  = 8'h4C;  // 'L'
    localparam logic [7:0]  c_CMD_RUN   = 8'h52;  // 'R'
    localparam logic [7:0]  c_CMD_STEP  = 8'h53;  // 'S'
    localparam logic [7:0]  c_CMD_RESET = 8'h58;  // 'X'

    localparam logic [15:0] c_HLT_WORD  = 16'h0000;

endpackage
`default_nettype wire

// File: rtl/debug_report_seq.sv
`default_nettype none
// ============================================================================
// Module      : debug_report_seq
// Description : Sends the CPU PC (16-bit, zero-extended) followed by
//               DUMP_WORDS data-memory words to the host, high byte first,
//               with TX valid/ready handshaking. Started by i_start, signals
//               completion with a one-cycle o_done.
// Revision    : 1.0 - initial release
// ============================================================================
module debug_report_seq
    import bip_debug_pkg::*;
#(
    parameter int NBITS_O    = 11,
    parameter int NBITS_D    = 16,
    parameter int DUMP_WORDS = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NBITS_O-1:0] i_PmAddr,
    output logic               o_done,
    output logic [7:0]         o_TxData,
    output logic               o_TxValid,
    input  logic               i_TxReady,
    output logic               o_DbgOwnsDm,
    output logic               o_DmRdEn,
    output logic [NBITS_O-1:0] o_DmAddr,
    input  logic [NBITS_D-1:0] i_DmRdData
);

    localparam logic [NBITS_O-1:0] c_LAST = NBITS_O'(DUMP_WORDS - 1);

    dbg_state_e         r_state;
    dbg_state_e         w_next_state;
    logic [15:0]        r_pc;
    logic [15:0]        r_word;
    logic [NBITS_O-1:0] r_idx;
    logic               w_last;

    assign w_last      = (r_idx == c_LAST);
    assign o_DbgOwnsDm = (r_state != IDLE);
    assign o_DmAddr    = o_DbgOwnsDm ? r_idx : '0;
    assign o_done      = (r_state == RP_DL) && i_TxReady && w_last;

    // State register plus PC snapshot, word capture and word index
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_word  <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_next_state;
            // PC is sampled in the start cycle, after the last CPU enable has landed
            if ((r_state == IDLE) && i_start) begin
                r_pc  <= 16'(i_PmAddr);
                r_idx <= '0;
            end
            if (r_state == RP_WAIT) begin
                r_word <= 16'(i_DmRdData);
            end
            if ((r_state == RP_DL) && i_TxReady && !w_last) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // Next-state and TX/DM output decode
    always_comb begin
        w_next_state = r_state;
        o_TxValid    = 1'b0;
        o_TxData     = 8'h00;
        o_DmRdEn     = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) w_next_state = RP_PCH;
            end
            RP_PCH: begin
                o_TxValid = 1'b1;
                o_TxData  = r_pc[15:8];
                if (i_TxReady) w_next_state = RP_PCL;
            end
            RP_PCL: begin
                o_TxValid = 1'b1;
                o_TxData  = r_pc[7:0];
                if (i_TxReady) w_next_state = RP_RD;
            end
            RP_RD: begin
                o_DmRdEn     = 1'b1;
                w_next_state = RP_WAIT;
            end
            RP_WAIT: begin
                w_next_state = RP_DH;
            end
            RP_DH: begin
                o_TxValid = 1'b1;
                o_TxData  = r_word[15:8];
                if (i_TxReady) w_next_state = RP_DL;
            end
            RP_DL: begin
                o_TxValid = 1'b1;
                o_TxData  = r_word[7:0];
                if (i_TxReady) w_next_state = w_last ? IDLE : RP_RD;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/bip_debug_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bip_debug_ctrl
// Description : Host debug controller for the accumulator CPU. Decodes host
//               command bytes, loads program memory, runs or single-steps the
//               CPU via its clock enable and hands off to the report sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module bip_debug_ctrl
    import bip_debug_pkg::*;
#(
    parameter int NBITS_O    = 11,
    parameter int NBITS_D    = 16,
    parameter int DUMP_WORDS = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [7:0]         i_RxData,
    input  logic               i_RxValid,
    output logic [7:0]         o_TxData,
    output logic               o_TxValid,
    input  logic               i_TxReady,
    input  logic               i_Halt,
    input  logic [NBITS_O-1:0] i_PmAddr,
    output logic               o_CpuEn,
    output logic               o_CpuReset,
    output logic               o_PmWrEn,
    output logic [NBITS_O-1:0] o_PmWrAddr,
    output logic [NBITS_D-1:0] o_PmWrData,
    output logic               o_DbgOwnsDm,
    output logic               o_DmRdEn,
    output logic [NBITS_O-1:0] o_DmAddr,
    input  logic [NBITS_D-1:0] i_DmRdData
);

    dbg_state_e         r_state;
    dbg_state_e         w_next_state;
    logic [NBITS_O-1:0] r_ld_addr;
    logic [7:0]         r_ld_hi;
    logic [NBITS_D-1:0] r_ld_word;
    logic               r_start;
    logic               w_go_report;
    logic               w_done;
    logic               w_abort;

    assign w_abort    = i_RxValid && (i_RxData == c_CMD_RESET);
    assign o_CpuEn    = ((r_state == RUN) || (r_state == STEP)) && !i_Halt;
    assign o_CpuReset = (r_state == LD_END) || (r_state == RST);
    assign o_PmWrEn   = (r_state == LD_WR);
    assign o_PmWrAddr = o_PmWrEn ? r_ld_addr : '0;
    assign o_PmWrData = o_PmWrEn ? r_ld_word : '0;

    // State register, loader address/data and report start pulse
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_ld_addr <= '0;
            r_ld_hi   <= '0;
            r_ld_word <= '0;
            r_start   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_start <= w_go_report;
            if ((r_state == IDLE) && i_RxValid && (i_RxData == c_CMD_LOAD)) begin
                r_ld_addr <= '0;
            end
            if ((r_state == LD_HI) && i_RxValid) begin
                r_ld_hi <= i_RxData;
            end
            if ((r_state == LD_LO) && i_RxValid) begin
                r_ld_word <= NBITS_D'({r_ld_hi, i_RxData});
            end
            if (r_state == LD_WR) begin
                r_ld_addr <= r_ld_addr + 1'b1;
            end
        end
    end

    // Command decode, loader sequencing and run/step control
    always_comb begin
        w_next_state = r_state;
        w_go_report  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_RxValid) begin
                    case (i_RxData)
                        c_CMD_LOAD:  w_next_state = LD_HI;
                        c_CMD_RUN:   w_next_state = RUN;
                        c_CMD_STEP:  w_next_state = STEP;
                        c_CMD_RESET: w_next_state = RST;
                        default:     w_next_state = IDLE;
                    endcase
                end
            end
            LD_HI: begin
                if (i_RxValid) w_next_state = LD_LO;
            end
            LD_LO: begin
                if (i_RxValid) w_next_state = LD_WR;
            end
            LD_WR: begin
                // HLT word or the top address terminates the load
                if ((r_ld_word == NBITS_D'(c_HLT_WORD)) || (r_ld_addr == '1)) begin
                    w_next_state = LD_END;
                end else begin
                    w_next_state = LD_HI;
                end
            end
            LD_END, RST: begin
                w_next_state = IDLE;
            end
            RUN: begin
                if (i_Halt || w_abort) begin
                    w_next_state = RP_PCH;
                    w_go_report  = 1'b1;
                end
            end
            STEP: begin
                w_next_state = RP_PCH;
                w_go_report  = 1'b1;
            end
            // Controller rests in RP_PCH while the sequencer walks the report
            RP_PCH: begin
                if (w_done) w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    debug_report_seq #(
        .NBITS_O    (NBITS_O),
        .NBITS_D    (NBITS_D),
        .DUMP_WORDS (DUMP_WORDS)
    ) u_report (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_start     (r_start),
        .i_PmAddr    (i_PmAddr),
        .o_done      (w_done),
        .o_TxData    (o_TxData),
        .o_TxValid   (o_TxValid),
        .i_TxReady   (i_TxReady),
        .o_DbgOwnsDm (o_DbgOwnsDm),
        .o_DmRdEn    (o_DmRdEn),
        .o_DmAddr    (o_DmAddr),
        .i_DmRdData  (i_DmRdData)
    );

endmodule
`default_nettype wire

// File: tb/tb_bip_debug_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bip_debug_ctrl
// Description : Scoreboard bench for bip_debug_ctrl with CPU, program-memory
//               and data-memory models and randomized host commands.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bip_debug_ctrl;
    import bip_debug_pkg::*;

    localparam int c_AW   = 4;
    localparam int c_DW   = 16;
    localparam int c_DUMP = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              rnd_ready = 1'b1;
    logic              hold_bp = 1'b0;
    logic              halt;
    logic [c_AW-1:0]   cpu_pc = '0;
    logic              cpu_en;
    logic              cpu_reset;
    logic              pm_wr_en;
    logic [c_AW-1:0]   pm_wr_addr;
    logic [c_DW-1:0]   pm_wr_data;
    logic              dbg_owns;
    logic              dm_rd_en;
    logic [c_AW-1:0]   dm_addr;
    logic [c_DW-1:0]   dm_q = '0;

    logic [15:0] pm_mem [0:15];
    logic [15:0] dm_mem [0:15];
    int          exec_total = 0;
    int          wr_cnt = 0;
    int          cpurst_cnt = 0;
    int          halt_mark = 0;

    logic [7:0]  exp_q [$];
    logic [15:0] ld_words [$];
    logic [3:0]  exp_pc = 4'h0;
    int          vectors = 0;
    int          fails = 0;
    logic        prev_hold = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    always #5 clk = ~clk;

    assign tx_ready = rnd_ready && !hold_bp;
    assign halt     = (exec_total >= halt_mark);

    bip_debug_ctrl #(
        .NBITS_O    (c_AW),
        .NBITS_D    (c_DW),
        .DUMP_WORDS (c_DUMP)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_RxData    (rx_data),
        .i_RxValid   (rx_valid),
        .o_TxData    (tx_data),
        .o_TxValid   (tx_valid),
        .i_TxReady   (tx_ready),
        .i_Halt      (halt),
        .i_PmAddr    (cpu_pc),
        .o_CpuEn     (cpu_en),
        .o_CpuReset  (cpu_reset),
        .o_PmWrEn    (pm_wr_en),
        .o_PmWrAddr  (pm_wr_addr),
        .o_PmWrData  (pm_wr_data),
        .o_DbgOwnsDm (dbg_owns),
        .o_DmRdEn    (dm_rd_en),
        .o_DmAddr    (dm_addr),
        .i_DmRdData  (dm_q)
    );

    // Environment: memories, CPU (PC advances per enable), activity counters
    always @(posedge clk) begin
        rnd_ready <= ($urandom_range(0, 3) != 0);
        if (dm_rd_en) dm_q <= dm_mem[dm_addr];
        if (pm_wr_en) begin
            pm_mem[pm_wr_addr] <= pm_wr_data;
            wr_cnt <= wr_cnt + 1;
        end
        if (cpu_en) exec_total <= exec_total + 1;
        if (cpu_reset) cpurst_cnt <= cpurst_cnt + 1;
        if (rst || cpu_reset) cpu_pc <= '0;
        else if (cpu_en) cpu_pc <= cpu_pc + 1'b1;
    end

    // Monitor: pops the scoreboard on every TX handshake, checks hold behaviour
    always @(negedge clk) begin
        if (rst) begin
            prev_hold <= 1'b0;
        end else begin
            if (prev_hold) begin
                vectors++;
                if (!(tx_valid && tx_data == prev_data)) begin
                    fails++;
                    $display("FAIL tx_hold: got valid=%0b data=%02h required valid=1 data=%02h",
                             tx_valid, tx_data, prev_data);
                end
            end
            if (tx_valid && tx_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL tx_extra: got byte %02h required no byte", tx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (tx_data != e) begin
                        fails++;
                        $display("FAIL tx_byte: got %02h required %02h", tx_data, e);
                    end
                end
            end
            if (dm_rd_en) begin
                vectors++;
                if (!dbg_owns) begin
                    fails++;
                    $display("FAIL dm_owner: got owns=0 required owns=1 during read");
                end
            end
            prev_hold <= tx_valid && !tx_ready;
            prev_data <= tx_data;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic push_report(input logic [3:0] pc);
        exp_q.push_back(8'h00);
        exp_q.push_back({4'h0, pc});
        for (int a = 0; a < c_DUMP; a++) begin
            exp_q.push_back(dm_mem[a][15:8]);
            exp_q.push_back(dm_mem[a][7:0]);
        end
    endtask

    task automatic wait_report();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        check("report_complete", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({tx_valid, tx_data, cpu_en, cpu_reset, pm_wr_en, pm_wr_addr,
                    pm_wr_data, dbg_owns, dm_rd_en, dm_addr});
    endfunction

    task automatic do_step(input int budget, input bit bp);
        int e0, steps, t;
        steps     = (budget > 0) ? 1 : 0;
        halt_mark = exec_total + budget;
        e0        = exec_total;
        exp_pc    = exp_pc + 4'(steps);
        push_report(exp_pc);
        send_byte(c_CMD_STEP);
        if (bp) begin
            t = 0;
            while (exp_q.size() > 9 && t < 1000) begin
                @(posedge clk);
                t++;
            end
            #1 hold_bp = 1'b1;
            repeat (10) @(posedge clk);
            #1 hold_bp = 1'b0;
        end
        wait_report();
        check("step_en_cycles", 64'(exec_total - e0), 64'(steps));
    endtask

    task automatic do_run(input int budget);
        int e0;
        halt_mark = exec_total + budget;
        e0        = exec_total;
        exp_pc    = exp_pc + 4'(budget);
        push_report(exp_pc);
        send_byte(c_CMD_RUN);
        wait_report();
        check("run_en_cycles", 64'(exec_total - e0), 64'(budget));
    endtask

    task automatic do_abort(input int k);
        int e0;
        halt_mark = exec_total + 1000;
        e0        = exec_total;
        exp_pc    = exp_pc + 4'(k + 2);
        push_report(exp_pc);
        send_byte(c_CMD_RUN);
        repeat (k) @(posedge clk);
        send_byte(c_CMD_RESET);
        @(negedge clk);
        check("abort_en_low", 64'(cpu_en), 64'd0);
        wait_report();
        check("abort_en_cycles", 64'(exec_total - e0), 64'(k + 2));
    endtask

    task automatic do_xreset();
        int r0;
        r0 = cpurst_cnt;
        send_byte(c_CMD_RESET);
        repeat (3) @(posedge clk);
        #1;
        check("x_reset_pulses", 64'(cpurst_cnt - r0), 64'd1);
        exp_pc = 4'h0;
    endtask

    // Sends ld_words as a load; expected write count follows HLT / top-address rule
    task automatic do_load();
        int w0, r0, n;
        w0 = wr_cnt;
        r0 = cpurst_cnt;
        n  = 0;
        for (int i = 0; i < ld_words.size(); i++) begin
            n++;
            if (ld_words[i] == 16'h0000 || n == 16) break;
        end
        send_byte(c_CMD_LOAD);
        for (int i = 0; i < ld_words.size(); i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            send_byte(ld_words[i][15:8]);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            send_byte(ld_words[i][7:0]);
        end
        repeat (3) @(posedge clk);
        #1;
        check("load_writes", 64'(wr_cnt - w0), 64'(n));
        check("load_cpu_reset", 64'(cpurst_cnt - r0), 64'd1);
        for (int i = 0; i < n; i++) begin
            check("load_pm_word", 64'(pm_mem[i]), 64'(ld_words[i]));
        end
        exp_pc = 4'h0;
    endtask

    initial begin
        int op;
        for (int i = 0; i < 16; i++) dm_mem[i] = 16'($urandom_range(0, 65535));
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", all_outputs(), 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Directed load of a three-word program
        ld_words = '{16'h0805, 16'h1801, 16'h0000};
        do_load();

        // Run three cycles to reach PC=3, then step to PC=4 under backpressure
        do_run(3);
        do_step(1, 1'b1);
        do_run(20);
        do_run(0);
        do_step(0, 1'b0);
        do_abort(5);

        // Top-address termination with all-nonzero words
        ld_words.delete();
        for (int i = 0; i < 16; i++) ld_words.push_back(16'($urandom_range(1, 65535)));
        do_load();
        do_xreset();

        // Reset while a report is in flight
        halt_mark = exec_total + 1;
        push_report(exp_pc + 4'd1);
        send_byte(c_CMD_STEP);
        begin
            int t;
            t = 0;
            while (exp_q.size() > 12 && t < 1000) begin
                @(posedge clk);
                t++;
            end
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midreport_reset_outputs", all_outputs(), 64'd0);
        exp_q.delete();
        exp_pc = 4'h0;
        repeat (2) @(posedge clk);
        do_step(1, 1'b0);

        // Randomized command mix
        for (int it = 0; it < 25; it++) begin
            op = $urandom_range(0, 3);
            case (op)
                0: do_step($urandom_range(0, 1), 1'($urandom_range(0, 1)));
                1: do_run($urandom_range(0, 30));
                2: begin
                    ld_words.delete();
                    for (int j = 0; j < $urandom_range(1, 4); j++)
                        ld_words.push_back(16'($urandom_range(1, 65535)));
                    ld_words.push_back(16'h0000);
                    do_load();
                end
                default: do_abort($urandom_range(0, 6));
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
`default_nettype wire
